// File: rtl/i2c_slave_regfile.sv
// I2C target: address match, register byte, one 32-bit word read/write.
// Optional macro I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample SCL/SDA filter.
module i2c_slave_regfile #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h63,
  parameter int         REG_DEPTH   = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        busy,
  output logic        reg_wr_valid,
  output logic [7:0]  reg_wr_addr,
  output logic [31:0] reg_wr_data
);
  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_r, sda_r, scl_s, sda_s, scl_q, sda_q;
  logic scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [2:0]  byte_cnt, byte_cnt_n;
  logic [6:0]  sh, sh_n;
  logic [7:0]  byte_in;
  logic        rw, rw_n, mack, mack_n, oe_n, commit;
  logic [7:0]  idx, idx_n;
  logic [31:0] shadow, shadow_n, wdata, wdata_n;
  logic [31:0] regs [REG_DEPTH];

  // input synchronizers, loaded with the idle-bus level on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign scl_r = scl_sync[SYNC_STAGES-1];
  assign sda_r = sda_sync[SYNC_STAGES-1];

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  logic       scl_hold, sda_hold;

  // level moves only after three equal consecutive samples
  always_comb begin
    scl_s = scl_hold;
    sda_s = sda_hold;
    if ({scl_h, scl_r} == 3'b111) scl_s = 1'b1;
    else if ({scl_h, scl_r} == 3'b000) scl_s = 1'b0;
    if ({sda_h, sda_r} == 3'b111) sda_s = 1'b1;
    else if ({sda_h, sda_r} == 3'b000) sda_s = 1'b0;
  end

  // filter sample history and held level
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_h    <= '1;
      sda_h    <= '1;
      scl_hold <= 1'b1;
      sda_hold <= 1'b1;
    end else begin
      scl_h    <= {scl_h[0], scl_r};
      sda_h    <= {sda_h[0], sda_r};
      scl_hold <= scl_s;
      sda_hold <= sda_s;
    end
  end
`else
  assign scl_s = scl_r;
  assign sda_s = sda_r;
`endif

  // previous sampled levels for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  // START/STOP only while SCL is steady high, so SCL edges win
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
  assign byte_in   = {sh, sda_s};
  assign busy      = (state != IDLE);

  // frame sequencing; sda_oe doubles as the ack-phase marker
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    sh_n       = sh;
    rw_n       = rw;
    mack_n     = mack;
    idx_n      = idx;
    shadow_n   = shadow;
    wdata_n    = wdata;
    oe_n       = sda_oe;
    commit     = 1'b0;
    if (start_det) begin
      state_n    = ADDR;
      bit_cnt_n  = '0;
      byte_cnt_n = '0;
      oe_n       = 1'b0;
    end else if (stop_det) begin
      state_n = IDLE;
      oe_n    = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sh_n      = byte_in[6:0];
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = '0;
            rw_n      = sda_s;
            state_n   = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
          end
        end
        REG: if (scl_rise) begin
          sh_n      = byte_in[6:0];
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = '0;
            if ({24'd0, byte_in} < 32'(REG_DEPTH)) begin
              state_n  = REG_ACK;
              idx_n    = byte_in;
              shadow_n = regs[byte_in[AW-1:0]];
            end else begin
              state_n = IGNORE;
            end
          end
        end
        WDATA: if (scl_rise) begin
          sh_n      = byte_in[6:0];
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            bit_cnt_n = '0;
            wdata_n   = {wdata[23:0], byte_in};
            if (byte_cnt == 3'd4) begin
              state_n = IGNORE;
            end else begin
              state_n = WDATA_ACK;
              commit  = (byte_cnt == 3'd3);
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          oe_n = ~sda_oe;
          if (sda_oe) state_n = REG;
        end
        REG_ACK: if (scl_fall) begin
          oe_n = ~sda_oe;
          if (sda_oe) begin
            state_n = rw ? RDATA : WDATA;
            if (rw) oe_n = ~shadow[31];
          end
        end
        WDATA_ACK: if (scl_fall) begin
          oe_n = ~sda_oe;
          if (sda_oe) begin
            state_n    = WDATA;
            byte_cnt_n = byte_cnt + 3'd1;
          end
        end
        RDATA: if (scl_rise) begin
          bit_cnt_n = bit_cnt + 4'd1;
          shadow_n  = {shadow[30:0], 1'b1};
        end else if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            oe_n      = 1'b0;
            bit_cnt_n = '0;
            state_n   = RDATA_ACK;
          end else begin
            oe_n = ~shadow[31];
          end
        end
        RDATA_ACK: if (scl_rise) begin
          mack_n = ~sda_s;
        end else if (scl_fall) begin
          if (mack && byte_cnt != 3'd3) begin
            byte_cnt_n = byte_cnt + 3'd1;
            state_n    = RDATA;
            oe_n       = ~shadow[31];
          end else begin
            state_n = IGNORE;
          end
        end
        default: oe_n = 1'b0;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      sh       <= '0;
      rw       <= 1'b0;
      mack     <= 1'b0;
      idx      <= '0;
      shadow   <= '0;
      wdata    <= '0;
      sda_oe   <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      byte_cnt <= byte_cnt_n;
      sh       <= sh_n;
      rw       <= rw_n;
      mack     <= mack_n;
      idx      <= idx_n;
      shadow   <= shadow_n;
      wdata    <= wdata_n;
      sda_oe   <= oe_n;
    end
  end

  // register file and write-commit strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
    end else begin
      reg_wr_valid <= commit;
      if (commit) begin
        regs[idx[AW-1:0]] <= wdata_n;
        reg_wr_addr       <= idx;
        reg_wr_data       <= wdata_n;
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged master plus frame-level model.
// Glitch check is built only with I2C_SLAVE_GLITCH_FILTER_EN.
module tb_i2c_slave_regfile;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_i;
  logic sda_oe, busy, reg_wr_valid;
  logic [7:0] reg_wr_addr;
  logic [31:0] reg_wr_data;

  assign sda_i = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regfile dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_i(sda_i),
    .sda_oe(sda_oe), .busy(busy), .reg_wr_valid(reg_wr_valid),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int wr_seen = 0;
  int exp_total = 0;
  logic [7:0] last_wa = '0;
  logic [31:0] last_wd = '0;
  logic [31:0] mregs [16];
  logic [39:0] exp_wr [$];
  logic prev_oe = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // per-cycle compare: write strobes against model, SDA moves only with SCL low
  always @(negedge clk) begin
    if (!rst) begin
      if (reg_wr_valid) begin
        wr_seen++;
        last_wa = reg_wr_addr;
        last_wd = reg_wr_data;
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got %0h_%0h expected none",
                   reg_wr_addr, reg_wr_data);
        end else begin
          check("write", {24'd0, reg_wr_addr, reg_wr_data},
                {24'd0, exp_wr.pop_front()});
        end
      end
      if (sda_oe !== prev_oe) check("oe_change_scl_low", {63'd0, scl}, 64'd0);
    end
    prev_oe = sda_oe;
  end

  task automatic clk_bit(input logic b, input bit glitch, output logic line);
    sda_m = b;
    if (glitch) begin
      repeat (4) @(negedge clk);
      scl = 1'b1;
      @(negedge clk);
      scl = 1'b0;
      repeat (Q - 5) @(negedge clk);
    end else begin
      repeat (Q) @(negedge clk);
    end
    scl = 1'b1;
    repeat (Q) @(negedge clk);
    line = sda_i;
    scl = 1'b0;
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    scl = 1'b0;
    repeat (Q) @(negedge clk);
    sda_m = 1'b1;
    repeat (Q) @(negedge clk);
    scl = 1'b1;
    repeat (Q) @(negedge clk);
    sda_m = 1'b0;
    repeat (Q) @(negedge clk);
    scl = 1'b0;
    repeat (Q) @(negedge clk);
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    repeat (Q) @(negedge clk);
    scl = 1'b1;
    repeat (Q) @(negedge clk);
    sda_m = 1'b1;
    repeat (2 * Q) @(negedge clk);
    check("busy_after_stop", {63'd0, busy}, 64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int g, output logic acked);
    logic line;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], (i == g), line);
    clk_bit(1'b1, 1'b0, line);
    acked = !line;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic line;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, line);
      b[i] = line;
    end
    clk_bit(!mack, 1'b0, line);
  endtask

  // model: ACK on match, reg < 16, first four data bytes; commit on 4th byte
  task automatic write_frame(input logic [6:0] a, input logic [7:0] r,
                             input logic [31:0] d, input int nb,
                             input bit do_stop, input int gl);
    logic ack;
    logic [7:0] bv;
    bit a_ok, r_ok;
    a_ok = (a == 7'h63);
    r_ok = a_ok && (r < 8'd16);
    i2c_start();
    send_byte({a, 1'b0}, -1, ack);
    check("w_addr_ack", {63'd0, ack}, {63'd0, a_ok});
    send_byte(r, -1, ack);
    check("w_reg_ack", {63'd0, ack}, {63'd0, r_ok});
    for (int i = 0; i < nb; i++) begin
      bv = (i < 4) ? d[31 - 8 * i -: 8] : 8'hA5;
      if (i == 3 && r_ok) begin
        exp_wr.push_back({r, d});
        exp_total++;
        mregs[r[3:0]] = d;
      end
      send_byte(bv, (i == gl) ? 4 : -1, ack);
      check($sformatf("w_data_ack%0d", i), {63'd0, ack},
            {63'd0, (r_ok && i < 4)});
    end
    if (do_stop) i2c_stop();
  endtask

  // model: bytes valid while previous ones ACKed and index < 4, else 0xFF
  task automatic read_frame(input logic [6:0] a, input logic [7:0] r,
                            input int nread, input int nack_at,
                            input bit do_stop, output logic [31:0] got);
    logic ack;
    logic [7:0] b, e;
    logic [31:0] word;
    bit a_ok, r_ok;
    a_ok = (a == 7'h63);
    r_ok = a_ok && (r < 8'd16);
    word = mregs[r[3:0]];
    got = '0;
    i2c_start();
    send_byte({a, 1'b1}, -1, ack);
    check("r_addr_ack", {63'd0, ack}, {63'd0, a_ok});
    send_byte(r, -1, ack);
    check("r_reg_ack", {63'd0, ack}, {63'd0, r_ok});
    for (int i = 0; i < nread; i++) begin
      recv_byte((i != nack_at) && (i != nread - 1), b);
      e = (r_ok && i < 4 && i <= nack_at) ? word[31 - 8 * i -: 8] : 8'hFF;
      check($sformatf("r_data%0d", i), {56'd0, b}, {56'd0, e});
      if (i < 4) got[31 - 8 * i -: 8] = b;
    end
    if (do_stop) i2c_stop();
  endtask

  initial begin
    logic [31:0] got;
    logic ack;
    int w0, nr;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_sda_oe", {63'd0, sda_oe}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_wr_valid", {63'd0, reg_wr_valid}, 64'd0);

    read_frame(7'h63, 8'h0F, 4, 3, 1'b1, got);
    check("read_0f_reset", {32'd0, got}, 64'h0);

    w0 = wr_seen;
    write_frame(7'h6B, 8'hBF, 32'h123458AE, 4, 1'b1, -1);
    check("wrong_addr_no_write", wr_seen - w0, 64'd0);
    write_frame(7'h63, 8'hFB, 32'h3458AE12, 4, 1'b1, -1);
    check("bad_reg_no_write", wr_seen - w0, 64'd0);

    write_frame(7'h63, 8'h0B, 32'h58AE1234, 4, 1'b1, -1);
    check("wr_pulse_count", wr_seen - w0, 64'd1);
    check("wr_addr", {56'd0, last_wa}, 64'h0B);
    check("wr_data", {32'd0, last_wd}, 64'h58AE1234);
    read_frame(7'h63, 8'h0B, 4, 3, 1'b1, got);
    check("read_0b", {32'd0, got}, 64'h58AE1234);

    write_frame(7'h63, 8'h0B, 32'hAABBCCDD, 2, 1'b1, -1);
    read_frame(7'h63, 8'h0B, 4, 3, 1'b1, got);
    check("partial_discard", {32'd0, got}, 64'h58AE1234);

    i2c_start();
    send_byte({7'h63, 1'b0}, -1, ack);
    send_byte(8'h0B, -1, ack);
    send_byte(8'hAA, -1, ack);
    for (int i = 0; i < 3; i++) clk_bit(1'b0, 1'b0, ack);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_sda_oe", {63'd0, sda_oe}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    write_frame(7'h63, 8'h05, 32'hCAFE0042, 4, 1'b1, -1);
    read_frame(7'h63, 8'h05, 4, 3, 1'b1, got);
    check("after_rst_read", {32'd0, got}, 64'hCAFE0042);
    read_frame(7'h63, 8'h0B, 4, 3, 1'b1, got);
    check("after_rst_cleared", {32'd0, got}, 64'h0);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    write_frame(7'h63, 8'h03, 32'hC35A0F96, 4, 1'b1, 1);
    read_frame(7'h63, 8'h03, 4, 3, 1'b1, got);
    check("glitch_rejected", {32'd0, got}, 64'hC35A0F96);
`endif

    for (int k = 0; k < 14; k++) begin
      logic [6:0] a;
      logic [7:0] r;
      a = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'h63;
      r = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255))
                                      : 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        write_frame(a, r, $urandom, $urandom_range(0, 5),
                    ($urandom_range(0, 3) != 0), -1);
      end else begin
        nr = $urandom_range(1, 6);
        read_frame(a, r, nr, $urandom_range(0, nr - 1),
                   ($urandom_range(0, 3) != 0), got);
      end
    end
    i2c_stop();
    repeat (4) @(negedge clk);
    check("pending_writes", exp_wr.size(), 64'd0);
    check("write_count", wr_seen, exp_total);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_cmp, n_fail);
    $finish;
  end
endmodule
